sii_dmu_inbound_rx: RTL and testbench

SII_DMU_INBOUND_RX -- requirements
Module: sii_dmu_inbound_rx

---
 rtl/sii_dmu_pkg.sv | 32 +++
 rtl/sii_dmu_wrtag_trk.sv | 60 ++++++
 rtl/sii_dmu_inbound_rx.sv | 171 +++++++++++++++++
 tb/tb_sii_dmu_inbound_rx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sii_dmu_pkg.sv
// Shared encodings for the DMU inbound receive path: packet types, FSM states,
// write-burst length, tag field location and the per-lane parity helper.
package sii_dmu_pkg;

    typedef enum logic [1:0] {
        PKT_RD    = 2'd0,
        PKT_WR    = 2'd1,
        PKT_MONDO = 2'd2,
        PKT_PIORD = 2'd3
    } pkt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WPAY = 2'd1,
        ST_MPAY = 2'd2
    } rx_state_e;

    localparam int WR_BEATS = 4;
    localparam int TAG_LSB  = 64;
    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 1 << TAG_W;

    // One even-parity bit per 16-bit lane of the data bus.
    function automatic logic [7:0] calc_parity(input logic [127:0] data);
        logic [7:0] par;
        for (int i = 0; i < 8; i++) begin
            par[i] = ^data[16*i +: 16];
        end
        return par;
    endfunction

endpackage

// File: rtl/sii_dmu_wrtag_trk.sv
// Write-tag busy tracker: marks tags busy on WR headers, releases them on
// forward-done (release takes effect before a same-cycle set) and returns wracks.
module sii_dmu_wrtag_trk
    import sii_dmu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_l_i,
    input  logic             set_vld_i,
    input  logic [TAG_W-1:0] set_tag_i,
    input  logic             rel_vld_i,
    input  logic [TAG_W-1:0] rel_tag_i,
    output logic             set_err_o,
    output logic             rel_err_o,
    output logic             wrack_vld_o,
    output logic [TAG_W-1:0] wrack_tag_o,
    output logic [4:0]       outstanding_o
);

    logic [NUM_TAGS-1:0] busy_q, busy_d, busy_rel;
    logic                rel_ok;
    logic                wrack_vld_q;
    logic [TAG_W-1:0]    wrack_tag_q;

    always_comb begin
        rel_ok   = rel_vld_i && busy_q[rel_tag_i];
        busy_rel = busy_q;
        if (rel_ok) begin
            busy_rel[rel_tag_i] = 1'b0;
        end
        set_err_o = set_vld_i && busy_rel[set_tag_i];
        rel_err_o = rel_vld_i && !rel_ok;
        busy_d    = busy_rel;
        if (set_vld_i) begin
            busy_d[set_tag_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_l_i) begin
            busy_q      <= '0;
            wrack_vld_q <= 1'b0;
            wrack_tag_q <= '0;
        end else begin
            busy_q      <= busy_d;
            wrack_vld_q <= rel_ok;
            wrack_tag_q <= rel_ok ? rel_tag_i : '0;
        end
    end

    always_comb begin
        outstanding_o = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            outstanding_o = outstanding_o + 5'(busy_q[i]);
        end
    end

    assign wrack_vld_o = wrack_vld_q;
    assign wrack_tag_o = wrack_tag_q;

endmodule

// File: rtl/sii_dmu_inbound_rx.sv
// DMU inbound receiver: decodes header cycles, frames payload beats into a
// registered beat stream, checks lane parity and flags protocol violations.
module sii_dmu_inbound_rx
    import sii_dmu_pkg::*;
(
    input  logic         iol2clk,
    input  logic         rst_l,
    input  logic         dmu_sii_hdr_vld,
    input  logic         dmu_sii_reqbypass,
    input  logic         dmu_sii_datareq,
    input  logic         dmu_sii_datareq16,
    input  logic [127:0] dmu_sii_data,
    input  logic [7:0]   dmu_sii_parity,
    input  logic [15:0]  dmu_sii_be,
    input  logic         wr_fwd_done,
    input  logic [3:0]   wr_fwd_tag,
    output logic         pkt_vld,
    output logic         pkt_hdr,
    output logic         pkt_last,
    output logic [1:0]   pkt_type,
    output logic         pkt_bypass,
    output logic [1:0]   pkt_beat,
    output logic [127:0] pkt_data,
    output logic [15:0]  pkt_be,
    output logic         sii_dmu_wrack_vld,
    output logic [3:0]   sii_dmu_wrack_tag,
    output logic         par_err,
    output logic         proto_err,
    output logic [4:0]   wr_outstanding
);

    rx_state_e    state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    pkt_type_e    type_q, type_d;
    logic         bypass_q, bypass_d;

    logic         vld_q, hdr_q, last_q, par_err_q, proto_err_q;
    logic         hdr_d, last_d;
    logic [1:0]   obeat_q, obeat_d;
    logic [127:0] data_q;
    logic [15:0]  be_q;

    pkt_type_e    hdr_type;
    logic         hdr_legal;
    logic         fwd, fsm_proto, wr_set, set_err, rel_err;

    always_comb begin
        hdr_type  = PKT_RD;
        hdr_legal = 1'b1;
        case ({dmu_sii_datareq, dmu_sii_datareq16})
            2'b00:   hdr_type = PKT_RD;
            2'b10:   hdr_type = PKT_WR;
            2'b11:   hdr_type = dmu_sii_reqbypass ? PKT_PIORD : PKT_MONDO;
            default: hdr_legal = 1'b0;
        endcase
    end

    // A header seen while a payload is in flight is ignored and the cycle is still payload.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        type_d    = type_q;
        bypass_d  = bypass_q;
        fwd       = 1'b0;
        hdr_d     = 1'b0;
        last_d    = 1'b0;
        obeat_d   = '0;
        fsm_proto = 1'b0;
        wr_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dmu_sii_hdr_vld) begin
                    if (!hdr_legal) begin
                        fsm_proto = 1'b1;
                    end else begin
                        fwd      = 1'b1;
                        hdr_d    = 1'b1;
                        type_d   = hdr_type;
                        bypass_d = dmu_sii_reqbypass;
                        beat_d   = '0;
                        case (hdr_type)
                            PKT_RD:  last_d  = 1'b1;
                            PKT_WR: begin
                                state_d = ST_WPAY;
                                wr_set  = 1'b1;
                            end
                            default: state_d = ST_MPAY;
                        endcase
                    end
                end
            end
            ST_WPAY: begin
                fwd       = 1'b1;
                obeat_d   = beat_q;
                fsm_proto = dmu_sii_hdr_vld;
                if (beat_q == 2'(WR_BEATS - 1)) begin
                    last_d  = 1'b1;
                    beat_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            ST_MPAY: begin
                fwd       = 1'b1;
                last_d    = 1'b1;
                fsm_proto = dmu_sii_hdr_vld;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sii_dmu_wrtag_trk u_wrtag_trk (
        .clk_i         (iol2clk),
        .rst_l_i       (rst_l),
        .set_vld_i     (wr_set),
        .set_tag_i     (dmu_sii_data[TAG_LSB +: TAG_W]),
        .rel_vld_i     (wr_fwd_done),
        .rel_tag_i     (wr_fwd_tag),
        .set_err_o     (set_err),
        .rel_err_o     (rel_err),
        .wrack_vld_o   (sii_dmu_wrack_vld),
        .wrack_tag_o   (sii_dmu_wrack_tag),
        .outstanding_o (wr_outstanding)
    );

    always_ff @(posedge iol2clk) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            type_q      <= PKT_RD;
            bypass_q    <= 1'b0;
            vld_q       <= 1'b0;
            hdr_q       <= 1'b0;
            last_q      <= 1'b0;
            obeat_q     <= '0;
            data_q      <= '0;
            be_q        <= '0;
            par_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            type_q      <= type_d;
            bypass_q    <= bypass_d;
            vld_q       <= fwd;
            hdr_q       <= hdr_d;
            last_q      <= last_d;
            obeat_q     <= obeat_d;
            par_err_q   <= fwd && (calc_parity(dmu_sii_data) != dmu_sii_parity);
            proto_err_q <= fsm_proto || set_err || rel_err;
            if (fwd) begin
                data_q <= dmu_sii_data;
                be_q   <= dmu_sii_be;
            end
        end
    end

    assign pkt_vld    = vld_q;
    assign pkt_hdr    = hdr_q;
    assign pkt_last   = last_q;
    assign pkt_type   = type_q;
    assign pkt_bypass = bypass_q;
    assign pkt_beat   = obeat_q;
    assign pkt_data   = data_q;
    assign pkt_be     = be_q;
    assign par_err    = par_err_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_sii_dmu_inbound_rx.sv
// Scoreboard bench for sii_dmu_inbound_rx: a packet-level model pushes expected
// beats, pulses, wracks and counts; a negedge monitor pops and compares them.
module tb_sii_dmu_inbound_rx;

    localparam int K_IDLE = 0;
    localparam int K_HDR  = 1;
    localparam int K_PAY  = 2;
    localparam int K_RST  = 3;

    logic         iol2clk = 1'b0;
    logic         rst_l = 1'b0;
    logic         dmu_sii_hdr_vld = 1'b0, dmu_sii_reqbypass = 1'b0;
    logic         dmu_sii_datareq = 1'b0, dmu_sii_datareq16 = 1'b0;
    logic [127:0] dmu_sii_data = '0;
    logic [7:0]   dmu_sii_parity = '0;
    logic [15:0]  dmu_sii_be = '0;
    logic         wr_fwd_done = 1'b0;
    logic [3:0]   wr_fwd_tag = '0;
    logic         pkt_vld, pkt_hdr, pkt_last, pkt_bypass;
    logic [1:0]   pkt_type, pkt_beat;
    logic [127:0] pkt_data;
    logic [15:0]  pkt_be;
    logic         sii_dmu_wrack_vld, par_err, proto_err;
    logic [3:0]   sii_dmu_wrack_tag;
    logic [4:0]   wr_outstanding;

    always #5 iol2clk = ~iol2clk;

    sii_dmu_inbound_rx dut (
        .iol2clk(iol2clk), .rst_l(rst_l),
        .dmu_sii_hdr_vld(dmu_sii_hdr_vld), .dmu_sii_reqbypass(dmu_sii_reqbypass),
        .dmu_sii_datareq(dmu_sii_datareq), .dmu_sii_datareq16(dmu_sii_datareq16),
        .dmu_sii_data(dmu_sii_data), .dmu_sii_parity(dmu_sii_parity), .dmu_sii_be(dmu_sii_be),
        .wr_fwd_done(wr_fwd_done), .wr_fwd_tag(wr_fwd_tag),
        .pkt_vld(pkt_vld), .pkt_hdr(pkt_hdr), .pkt_last(pkt_last), .pkt_type(pkt_type),
        .pkt_bypass(pkt_bypass), .pkt_beat(pkt_beat), .pkt_data(pkt_data), .pkt_be(pkt_be),
        .sii_dmu_wrack_vld(sii_dmu_wrack_vld), .sii_dmu_wrack_tag(sii_dmu_wrack_tag),
        .par_err(par_err), .proto_err(proto_err), .wr_outstanding(wr_outstanding)
    );

    typedef struct {
        int           stamp;
        logic         hdr;
        logic         last;
        logic [1:0]   typ;
        logic         byp;
        logic [1:0]   beat;
        logic [127:0] data;
        logic [15:0]  be;
        logic         par;
    } beat_t;
    typedef struct { int stamp; int cnt; } cnt_t;
    typedef struct { int stamp; logic [3:0] tag; } ack_t;

    beat_t beatQ[$];
    cnt_t  outQ[$];
    ack_t  ackQ[$];
    int    protoQ[$];
    int    zeroQ[$];

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;

    // Reference state: which tags are in flight, and the packet currently being streamed.
    bit         busy[16];
    logic [1:0] curType = 2'd0;
    logic       curByp = 1'b0;
    int         payIdx = 0;
    int         payLen = 0;
    bit         randDone = 0;

    always @(posedge iol2clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] randData();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One input cycle; the model derives what the DUT must show on the following cycle.
    task automatic applyStimulus(input int kind, input logic hv, input logic byp, input logic [1:0] code,
                                 input logic [127:0] data, input logic [7:0] flip, input logic [15:0] be,
                                 input logic done, input logic [3:0] dtag);
        int         stamp;
        int         cnt;
        logic [7:0] par;
        bit         proto;
        bit         legal;
        logic [1:0] typ;
        logic [3:0] wtag;
        beat_t      b;
        stamp = cyc + 1;
        for (int i = 0; i < 8; i++) par[i] = ^data[16*i +: 16];
        rst_l             = (kind != K_RST);
        dmu_sii_hdr_vld   = hv;
        dmu_sii_reqbypass = byp;
        dmu_sii_datareq   = code[1];
        dmu_sii_datareq16 = code[0];
        dmu_sii_data      = data;
        dmu_sii_parity    = par ^ flip;
        dmu_sii_be        = be;
        wr_fwd_done       = done;
        wr_fwd_tag        = dtag;
        proto = 0;
        typ   = 2'd0;
        if (kind == K_RST) begin
            foreach (busy[i]) busy[i] = 0;
            payLen = 0;
            payIdx = 0;
            zeroQ.push_back(stamp);
        end else begin
            if (done) begin
                if (busy[dtag]) begin
                    busy[dtag] = 0;
                    ackQ.push_back('{stamp: stamp, tag: dtag});
                end else begin
                    proto = 1;
                end
            end
            b.stamp = stamp;
            b.data  = data;
            b.be    = be;
            b.par   = |flip;
            if (kind == K_HDR) begin
                legal = 1;
                case (code)
                    2'b00:   typ = 2'd0;
                    2'b10:   typ = 2'd1;
                    2'b11:   typ = byp ? 2'd3 : 2'd2;
                    default: legal = 0;
                endcase
                if (!legal) begin
                    proto = 1;
                end else begin
                    curType = typ;
                    curByp  = byp;
                    payIdx  = 0;
                    payLen  = (typ == 2'd0) ? 0 : (typ == 2'd1) ? 4 : 1;
                    b.hdr  = 1'b1;
                    b.last = (typ == 2'd0);
                    b.typ  = typ;
                    b.byp  = byp;
                    b.beat = 2'd0;
                    beatQ.push_back(b);
                    if (typ == 2'd1) begin
                        wtag = data[67:64];
                        if (busy[wtag]) proto = 1;
                        busy[wtag] = 1;
                    end
                end
            end else if (kind == K_PAY) begin
                b.hdr  = 1'b0;
                b.last = (payIdx == payLen - 1);
                b.typ  = curType;
                b.byp  = curByp;
                b.beat = 2'(payIdx);
                beatQ.push_back(b);
                payIdx++;
                if (hv) proto = 1;
            end
            if (proto) protoQ.push_back(stamp);
        end
        cnt = 0;
        foreach (busy[i]) cnt += int'(busy[i]);
        outQ.push_back('{stamp: stamp, cnt: cnt});
        @(posedge iol2clk);
        #1;
    endtask

    task automatic pickDone(output logic dn, output logic [3:0] dt);
        int live[$];
        dn = 1'b0;
        dt = 4'($urandom_range(0, 15));
        if (randDone && $urandom_range(0, 3) == 0) begin
            dn = 1'b1;
            foreach (busy[i]) if (busy[i]) live.push_back(i);
            if (live.size() > 0 && $urandom_range(0, 3) != 0)
                dt = 4'(live[$urandom_range(0, live.size() - 1)]);
        end
    endtask

    task automatic idleCycle();
        logic dn;
        logic [3:0] dt;
        pickDone(dn, dt);
        applyStimulus(K_IDLE, 1'b0, 1'($urandom), 2'($urandom), randData(), 8'h00, 16'($urandom), dn, dt);
    endtask

    // flipBeat: -1 none, 0 header, k+1 payload beat k; intrude: payload beat carrying a stray hdr_vld.
    task automatic sendPacket(input logic [1:0] code, input logic byp, input logic [3:0] tag,
                              input int intrude, input int flipBeat, input logic [7:0] mask);
        logic [127:0] d;
        logic dn;
        logic [3:0] dt;
        int n;
        d = randData();
        d[67:64] = tag;
        n = (code == 2'b10) ? 4 : (code == 2'b11) ? 1 : 0;
        pickDone(dn, dt);
        applyStimulus(K_HDR, 1'b1, byp, code, d, (flipBeat == 0) ? mask : 8'h00, 16'($urandom), dn, dt);
        for (int k = 0; k < n; k++) begin
            pickDone(dn, dt);
            applyStimulus(K_PAY, (k == intrude), 1'($urandom), 2'($urandom), randData(),
                          (flipBeat == k + 1) ? mask : 8'h00, 16'($urandom), dn, dt);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents (or should present) an output.
    always @(negedge iol2clk) begin
        beat_t b;
        bit    expProto;
        while (beatQ.size() > 0 && beatQ[0].stamp < cyc) begin
            b = beatQ.pop_front();
            checkOutput("missed beat stamp", 256'(cyc), 256'(b.stamp));
        end
        if (pkt_vld === 1'b1 && beatQ.size() > 0) begin
            b = beatQ.pop_front();
            checkOutput("beat", {32'(cyc), pkt_hdr, pkt_last, pkt_type, pkt_bypass, pkt_beat, pkt_data, pkt_be, par_err},
                                {32'(b.stamp), b.hdr, b.last, b.typ, b.byp, b.beat, b.data, b.be, b.par});
        end else begin
            checkOutput("pkt_vld", 256'(pkt_vld), 256'(0));
            checkOutput("par_err without beat", 256'(par_err), 256'(0));
        end
        expProto = (protoQ.size() > 0 && protoQ[0] == cyc);
        if (expProto) void'(protoQ.pop_front());
        checkOutput("proto_err", 256'(proto_err), 256'(expProto));
        if (ackQ.size() > 0 && ackQ[0].stamp == cyc) begin
            checkOutput("wrack", {sii_dmu_wrack_vld, sii_dmu_wrack_tag}, {1'b1, ackQ[0].tag});
            void'(ackQ.pop_front());
        end else begin
            checkOutput("wrack_vld", 256'(sii_dmu_wrack_vld), 256'(0));
        end
        if (outQ.size() > 0 && outQ[0].stamp == cyc) begin
            checkOutput("wr_outstanding", 256'(wr_outstanding), 256'(outQ[0].cnt));
            void'(outQ.pop_front());
        end
        if (zeroQ.size() > 0 && zeroQ[0] == cyc) begin
            checkOutput("outputs after reset",
                256'({pkt_vld, pkt_hdr, pkt_last, pkt_type, pkt_bypass, pkt_beat, pkt_data, pkt_be,
                      sii_dmu_wrack_vld, sii_dmu_wrack_tag, par_err, proto_err, wr_outstanding}), 256'(0));
            void'(zeroQ.pop_front());
        end
    end

    initial begin
        int r;
        int intrude;
        int flipBeat;
        logic [1:0] code;
        logic [127:0] d;
        applyStimulus(K_RST, 1'b1, 1'b1, 2'b10, randData(), 8'h00, 16'hffff, 1'b1, 4'd3);
        applyStimulus(K_RST, 1'b0, 1'b0, 2'b00, '0, 8'h00, 16'h0000, 1'b0, 4'd0);
        idleCycle();

        $display("[TB] RD header with bypass");
        applyStimulus(K_HDR, 1'b1, 1'b1, 2'b00, 128'h12_3456_7800, 8'h00, 16'h00ff, 1'b0, 4'd0);
        idleCycle();

        $display("[TB] WR tag 5 then forward-done");
        sendPacket(2'b10, 1'b0, 4'd5, -1, -1, 8'h00);
        applyStimulus(K_IDLE, 1'b0, 1'b0, 2'b00, randData(), 8'h00, 16'h0, 1'b1, 4'd5);
        idleCycle();

        $display("[TB] MONDO then PIORD back to back");
        sendPacket(2'b11, 1'b0, 4'd0, -1, -1, 8'h00);
        sendPacket(2'b11, 1'b1, 4'd0, -1, -1, 8'h00);

        $display("[TB] header during WR payload beat 2");
        sendPacket(2'b10, 1'b0, 4'd9, 2, -1, 8'h00);

        $display("[TB] parity error on MONDO payload, duplicate WR tag 7");
        sendPacket(2'b11, 1'b0, 4'd0, -1, 1, 8'h08);
        sendPacket(2'b10, 1'b0, 4'd7, -1, 0, 8'h01);
        sendPacket(2'b10, 1'b1, 4'd7, -1, -1, 8'h00);

        $display("[TB] same-cycle release and reuse of tag 7");
        d = randData();
        d[67:64] = 4'd7;
        applyStimulus(K_HDR, 1'b1, 1'b0, 2'b10, d, 8'h00, 16'hbeef, 1'b1, 4'd7);
        for (int k = 0; k < 4; k++)
            applyStimulus(K_PAY, 1'b0, 1'b0, 2'b00, randData(), 8'h00, 16'($urandom), 1'b0, 4'd0);
        applyStimulus(K_IDLE, 1'b0, 1'b0, 2'b00, randData(), 8'h00, 16'h0, 1'b1, 4'd3);
        applyStimulus(K_IDLE, 1'b0, 1'b0, 2'b00, randData(), 8'h00, 16'h0, 1'b1, 4'd9);

        $display("[TB] illegal header, then reset mid-WR");
        applyStimulus(K_HDR, 1'b1, 1'b0, 2'b01, randData(), 8'h00, 16'h1234, 1'b0, 4'd0);
        d = randData();
        d[67:64] = 4'd2;
        applyStimulus(K_HDR, 1'b1, 1'b0, 2'b10, d, 8'h00, 16'h5555, 1'b0, 4'd0);
        applyStimulus(K_PAY, 1'b0, 1'b0, 2'b00, randData(), 8'h00, 16'haaaa, 1'b0, 4'd0);
        applyStimulus(K_RST, 1'b0, 1'b0, 2'b00, randData(), 8'h00, 16'h0f0f, 1'b1, 4'd7);
        applyStimulus(K_HDR, 1'b1, 1'b0, 2'b00, randData(), 8'h00, 16'h00f0, 1'b0, 4'd0);
        idleCycle();

        $display("[TB] randomized traffic");
        randDone = 1;
        for (int p = 0; p < 120; p++) begin
            r = $urandom_range(0, 19);
            if (r < 4)       code = 2'b00;
            else if (r < 10) code = 2'b10;
            else if (r < 18) code = 2'b11;
            else             code = 2'b01;
            intrude  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            flipBeat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            sendPacket(code, 1'($urandom), 4'($urandom_range(0, 15)), intrude, flipBeat,
                       8'(1 << $urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) idleCycle();
            if ($urandom_range(0, 29) == 0)
                applyStimulus(K_RST, 1'($urandom), 1'b0, 2'($urandom), randData(), 8'h00, 16'h0, 1'b0, 4'd0);
        end

        randDone = 0;
        for (int t = 0; t < 16; t++)
            if (busy[t]) applyStimulus(K_IDLE, 1'b0, 1'b0, 2'b00, randData(), 8'h00, 16'h0, 1'b1, 4'(t));
        repeat (3) idleCycle();
        @(negedge iol2clk);
        #1;
        checkOutput("beats left undelivered", 256'(beatQ.size()), 256'(0));
        checkOutput("proto_err pulses left", 256'(protoQ.size()), 256'(0));
        checkOutput("wracks left", 256'(ackQ.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
